// File: rtl/axi_lite_ram_slave.sv
// AXI-Lite slave in front of a word-organised single-port synchronous RAM.
// Handles single/burst writes (terminated by wlast) and fixed-length read bursts.
module axi_lite_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned RD_BEATS    = 1,
  parameter bit          WAIT_BREADY = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  input  logic        wlast,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  output logic        rlast,
  input  logic        rready
);

  localparam int unsigned IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] SPAN      = 33'(MEM_DEPTH) * 33'd4;
  localparam logic [4:0]  LAST_BEAT = 5'(RD_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_MEM,
    RD_RESP
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [31:0] r_mem [MEM_DEPTH];
  logic [31:0] r_addr;
  logic [4:0]  r_beat;
  logic        r_err;
  logic        r_bvalid;
  logic [1:0]  r_bresp;
  logic        r_rvalid;
  logic        r_rlast;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic [32:0]      w_off;
  logic             w_in_range;
  logic [IDX_W-1:0] w_idx;
  logic             w_aw_fire;
  logic             w_ar_fire;
  logic             w_w_fire;
  logic             w_b_done;

  // 33-bit subtraction: a borrow into bit 32 means the address is below BASE_ADDR.
  assign w_off      = {1'b0, r_addr} - {1'b0, BASE_ADDR};
  assign w_in_range = !w_off[32] && (w_off < SPAN);
  assign w_idx      = w_off[IDX_W+1:2];

  assign awready = (r_state == IDLE);
  assign arready = (r_state == IDLE) && !awvalid;
  assign wready  = (r_state == WR_DATA);

  assign w_aw_fire = awvalid && awready;
  assign w_ar_fire = arvalid && arready;
  assign w_w_fire  = wvalid && wready;
  assign w_b_done  = !WAIT_BREADY || bready;

  assign bvalid = r_bvalid;
  assign bresp  = r_bresp;
  assign rvalid = r_rvalid;
  assign rlast  = r_rlast;
  assign rdata  = r_rdata;
  assign rresp  = r_rresp;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_aw_fire) begin
          w_next_state = WR_DATA;
        end else if (w_ar_fire) begin
          w_next_state = RD_MEM;
        end
      end
      WR_DATA: begin
        if (w_w_fire && wlast) begin
          w_next_state = WR_RESP;
        end
      end
      WR_RESP: begin
        if (w_b_done) begin
          w_next_state = IDLE;
        end
      end
      RD_MEM: begin
        w_next_state = RD_RESP;
      end
      RD_RESP: begin
        if (rready) begin
          w_next_state = r_rlast ? IDLE : RD_MEM;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_beat   <= '0;
      r_err    <= 1'b0;
      r_bvalid <= 1'b0;
      r_bresp  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_fire) begin
            r_addr <= awaddr;
            r_err  <= 1'b0;
          end else if (w_ar_fire) begin
            r_addr <= araddr;
            r_beat <= '0;
            r_err  <= 1'b0;
          end
        end
        WR_DATA: begin
          if (w_w_fire) begin
            if (!w_in_range) begin
              r_err <= 1'b1;
            end
            r_addr <= r_addr + 32'd4;
            if (wlast) begin
              // The final beat's own range error is folded in directly.
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err || !w_in_range) ? 2'b10 : 2'b00;
            end
          end
        end
        WR_RESP: begin
          if (w_b_done) begin
            r_bvalid <= 1'b0;
          end
        end
        RD_MEM: begin
          r_rdata  <= w_in_range ? r_mem[w_idx] : '0;
          r_rresp  <= w_in_range ? 2'b00 : 2'b10;
          r_rlast  <= (r_beat == LAST_BEAT);
          r_rvalid <= 1'b1;
        end
        RD_RESP: begin
          if (rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            if (!r_rlast) begin
              r_beat <= r_beat + 5'd1;
              r_addr <= r_addr + 32'd4;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (resetn && w_w_fire && w_in_range) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          r_mem[w_idx][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Randomised self-checking bench for axi_lite_ram_slave: two instances with
// different geometries, compared against a word-array reference model.
module tb_axi_lite_ram_slave;

  localparam logic [31:0] BASE0  = 32'h0000_1000;
  localparam int          DEPTH0 = 16;
  localparam int          BEATS0 = 3;
  localparam int          DEPTH1 = 4;
  localparam int          BEATS1 = 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr [2];
  logic        awvalid[2];
  logic        awready[2];
  logic [31:0] wdata  [2];
  logic [3:0]  wstrb  [2];
  logic        wvalid [2];
  logic        wlast  [2];
  logic        wready [2];
  logic [1:0]  bresp  [2];
  logic        bvalid [2];
  logic        bready [2];
  logic [31:0] araddr [2];
  logic        arvalid[2];
  logic        arready[2];
  logic [31:0] rdata  [2];
  logic [1:0]  rresp  [2];
  logic        rvalid [2];
  logic        rlast  [2];
  logic        rready [2];

  int n_chk  = 0;
  int n_pass = 0;
  int last_waits = 0;
  bit chk_ar = 1'b0;

  logic [31:0] mdl [2][16];
  logic [31:0] q_dat[$];
  logic [3:0]  q_strb[$];

  axi_lite_ram_slave #(.BASE_ADDR(BASE0), .MEM_DEPTH(DEPTH0), .RD_BEATS(BEATS0),
                       .WAIT_BREADY(1'b1)) u_dut0 (
    .clk(clk), .resetn(resetn),
    .awaddr(awaddr[0]), .awvalid(awvalid[0]), .awready(awready[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .wvalid(wvalid[0]), .wlast(wlast[0]),
    .wready(wready[0]), .bresp(bresp[0]), .bvalid(bvalid[0]), .bready(bready[0]),
    .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rlast(rlast[0]),
    .rready(rready[0])
  );

  axi_lite_ram_slave #(.BASE_ADDR(32'h0), .MEM_DEPTH(DEPTH1), .RD_BEATS(BEATS1),
                       .WAIT_BREADY(1'b0)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .awaddr(awaddr[1]), .awvalid(awvalid[1]), .awready(awready[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .wvalid(wvalid[1]), .wlast(wlast[1]),
    .wready(wready[1]), .bresp(bresp[1]), .bvalid(bvalid[1]), .bready(bready[1]),
    .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rlast(rlast[1]),
    .rready(rready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : 32'h0;
  endfunction

  function automatic int depth_of(input int d);
    return (d == 0) ? DEPTH0 : DEPTH1;
  endfunction

  function automatic int beats_of(input int d);
    return (d == 0) ? BEATS0 : BEATS1;
  endfunction

  function automatic bit in_range(input int d, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(base_of(d));
    return (off >= 0) && (off < longint'(4 * depth_of(d)));
  endfunction

  function automatic int widx(input int d, input logic [31:0] a);
    return int'((a - base_of(d)) >> 2);
  endfunction

  function automatic void mdl_write(input int d, input logic [31:0] a,
                                    input logic [31:0] dat, input logic [3:0] st);
    for (int i = 0; i < 4; i++)
      if (st[i]) mdl[d][widx(d, a)][8*i +: 8] = dat[8*i +: 8];
  endfunction

  function automatic logic rdy(input int d, input int sel);
    case (sel)
      0:       return awready[d];
      1:       return arready[d];
      default: return wready[d];
    endcase
  endfunction

  // Called at posedge+1 with valid driven; returns at posedge+1 after the handshake edge.
  task automatic wait_hs(input int d, input int sel, input string tag);
    last_waits = 0;
    @(negedge clk);
    while (!rdy(d, sel) && last_waits < 50) begin
      @(negedge clk);
      last_waits++;
    end
    if (!rdy(d, sel)) check(tag, 32'(rdy(d, sel)), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wr_burst(input int d, input logic [31:0] addr, input int n);
    logic [31:0] a;
    logic [31:0] dat;
    logic [3:0]  st;
    bit          err;
    int          hold;
    a = addr;
    err = 1'b0;
    awaddr[d]  = addr;
    awvalid[d] = 1'b1;
    wait_hs(d, 0, "aw_timeout");
    awvalid[d] = 1'b0;
    if (chk_ar) check("arready_blocked_wr", 32'(arready[d]), 32'd0);
    for (int b = 0; b < n; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        wvalid[d] = 1'b0;
        @(posedge clk); #1;
      end
      dat = (q_dat.size() > 0) ? q_dat.pop_front() : $urandom;
      st  = (q_strb.size() > 0) ? q_strb.pop_front() : 4'($urandom);
      wdata[d]  = dat;
      wstrb[d]  = st;
      wvalid[d] = 1'b1;
      wlast[d]  = (b == n - 1);
      wait_hs(d, 2, "w_timeout");
      if (in_range(d, a)) mdl_write(d, a, dat, st);
      else err = 1'b1;
      a += 32'd4;
    end
    wvalid[d] = 1'b0;
    wlast[d]  = 1'b0;
    @(negedge clk);
    check("bvalid_set", 32'(bvalid[d]), 32'd1);
    check("bresp", 32'(bresp[d]), err ? 32'd2 : 32'd0);
    if (chk_ar) check("arready_blocked_resp", 32'(arready[d]), 32'd0);
    if (d == 0) begin
      hold = $urandom_range(0, 2);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("bvalid_hold", 32'(bvalid[d]), 32'd1);
        check("bresp_hold", 32'(bresp[d]), err ? 32'd2 : 32'd0);
      end
      bready[d] = 1'b1;
      @(posedge clk); #1;
      bready[d] = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    check("bvalid_clr", 32'(bvalid[d]), 32'd0);
    check("awready_idle", 32'(awready[d]), 32'd1);
  endtask

  task automatic rd_burst(input int d, input logic [31:0] addr);
    logic [31:0] a;
    logic [31:0] exp_d;
    logic [31:0] exp_r;
    int          hold;
    int          ar_waits;
    a = addr;
    araddr[d]  = addr;
    arvalid[d] = 1'b1;
    wait_hs(d, 1, "ar_timeout");
    ar_waits   = last_waits;
    arvalid[d] = 1'b0;
    for (int b = 0; b < beats_of(d); b++) begin
      @(negedge clk);
      check("rvalid_mem_cycle", 32'(rvalid[d]), 32'd0);
      @(negedge clk);
      exp_d = in_range(d, a) ? mdl[d][widx(d, a)] : 32'h0;
      exp_r = in_range(d, a) ? 32'd0 : 32'd2;
      hold  = $urandom_range(0, 2);
      for (int h = 0; h <= hold; h++) begin
        if (h > 0) @(negedge clk);
        check("rvalid", 32'(rvalid[d]), 32'd1);
        check("rdata", rdata[d], exp_d);
        check("rresp", 32'(rresp[d]), exp_r);
        check("rlast", 32'(rlast[d]), (b == beats_of(d) - 1) ? 32'd1 : 32'd0);
      end
      rready[d] = 1'b1;
      @(posedge clk); #1;
      rready[d] = 1'b0;
      a += 32'd4;
    end
    check("rvalid_clr", 32'(rvalid[d]), 32'd0);
    check("rlast_clr", 32'(rlast[d]), 32'd0);
    last_waits = ar_waits;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          d;
    int          n;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; awvalid[i] = 1'b0; wdata[i] = '0; wstrb[i] = '0;
      wvalid[i] = 1'b0; wlast[i] = 1'b0; bready[i] = 1'b0; araddr[i] = '0;
      arvalid[i] = 1'b0; rready[i] = 1'b0;
    end

    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_bvalid", 32'(bvalid[i]), 32'd0);
      check("rst_rvalid", 32'(rvalid[i]), 32'd0);
      check("rst_rlast", 32'(rlast[i]), 32'd0);
      check("rst_rdata", rdata[i], 32'd0);
      check("rst_bresp", 32'(bresp[i]), 32'd0);
      check("rst_rresp", 32'(rresp[i]), 32'd0);
      check("rst_awready", 32'(awready[i]), 32'd1);
      check("rst_arready", 32'(arready[i]), 32'd1);
      check("rst_wready", 32'(wready[i]), 32'd0);
    end
    @(posedge clk); #1;

    // Fill both memories so every later read has a known model value.
    for (int i = 0; i < DEPTH0; i++) q_strb.push_back(4'hF);
    wr_burst(0, BASE0, DEPTH0);
    for (int i = 0; i < DEPTH1; i++) q_strb.push_back(4'hF);
    wr_burst(1, 32'h0, DEPTH1);

    q_dat.push_back(32'hDEAD_BEEF); q_strb.push_back(4'hF);
    wr_burst(0, BASE0 + 32'h10, 1);
    rd_burst(0, BASE0 + 32'h10);
    q_dat.push_back(32'h1122_3344); q_strb.push_back(4'b0101);
    wr_burst(0, BASE0 + 32'h10, 1);
    rd_burst(0, BASE0 + 32'h10);

    for (int i = 1; i <= 3; i++) begin
      q_dat.push_back(32'(i)); q_strb.push_back(4'hF);
    end
    wr_burst(0, BASE0 + 32'h20, 3);
    rd_burst(0, BASE0 + 32'h20);

    q_strb.push_back(4'hF); q_strb.push_back(4'hF);
    wr_burst(1, 32'h0C, 2);
    rd_burst(1, 32'h0C);
    rd_burst(1, 32'h40);
    rd_burst(0, BASE0 + 32'h38);
    rd_burst(0, BASE0 - 32'h4);
    wr_burst(1, 32'h04, 1);
    wr_burst(1, 32'h08, 1);
    rd_burst(1, 32'h04);

    // Simultaneous AW and AR: write first, AR accepted on the first IDLE cycle.
    araddr[0]  = BASE0 + 32'h4;
    arvalid[0] = 1'b1;
    chk_ar = 1'b1;
    wr_burst(0, BASE0, 1);
    chk_ar = 1'b0;
    rd_burst(0, BASE0 + 32'h4);
    check("ar_accept_after_write", 32'(last_waits), 32'd0);

    // Reset after the second beat of a burst.
    awaddr[0] = BASE0 + 32'h20; awvalid[0] = 1'b1;
    wait_hs(0, 0, "aw_timeout");
    awvalid[0] = 1'b0;
    a = BASE0 + 32'h20;
    for (int b = 0; b < 2; b++) begin
      wdata[0] = $urandom; wstrb[0] = 4'hF; wvalid[0] = 1'b1; wlast[0] = 1'b0;
      wait_hs(0, 2, "w_timeout");
      mdl_write(0, a, wdata[0], 4'hF);
      a += 32'd4;
    end
    wvalid[0] = 1'b0;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_bvalid", 32'(bvalid[0]), 32'd0);
    check("midrst_rvalid", 32'(rvalid[0]), 32'd0);
    check("midrst_wready", 32'(wready[0]), 32'd0);
    check("midrst_awready", 32'(awready[0]), 32'd1);
    @(posedge clk); #1;
    rd_burst(0, BASE0 + 32'h20);

    for (int it = 0; it < 40; it++) begin
      d = $urandom_range(0, 1);
      n = $urandom_range(1, 4);
      a = base_of(d) + 32'($urandom_range(0, depth_of(d) + 2) * 4) + 32'($urandom_range(0, 3));
      if (d == 0 && $urandom_range(0, 7) == 0) a = BASE0 - 32'($urandom_range(1, 3) * 4);
      if ($urandom_range(0, 1) == 0) wr_burst(d, a, n);
      else rd_burst(d, a);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_lite_ram_slave.md
Name: axi_lite_ram_slave

Overview:
- AXI-Lite slave wrapping a word-organised, single-port synchronous RAM; sits directly downstream of the core-side AXI-Lite master bridge on the core_master bus.
- Serves single writes, burst writes (one AW, then W beats until wlast) and single or burst reads (one AR, then RD_BEATS R beats, final beat flagged with rlast).
- Word address increments by 4 per beat. Out-of-range accesses complete normally with SLVERR.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- MEM_DEPTH, 1024, number of 32-bit words.
- RD_BEATS, 1, R beats returned per AR handshake (1..16).
- WAIT_BREADY, 1: 1 = bvalid held until bready; 0 = bvalid pulses one cycle and the FSM proceeds regardless.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- awaddr  in  32  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte enables.
- wvalid  in  1  write data valid.
- wlast  in  1  final write beat.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  32  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read data valid.
- rlast  out  1  final read beat.
- rready  in  1  read data ready.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on resetn.
- Reset values: state=IDLE; bvalid=0, rvalid=0, rlast=0; rdata=0; bresp=0, rresp=0; beat counter=0; error flag=0. RAM contents are not reset.
- Ready outputs (combinational from state):
  - awready = (state==IDLE).
  - arready = (state==IDLE) && !awvalid. Write wins a simultaneous AW/AR; AR stays pending.
  - wready = (state==WR_DATA).
- Address decode: in range iff BASE_ADDR <= addr < BASE_ADDR + 4*MEM_DEPTH. Word index = (addr-BASE_ADDR)>>2; addr[1:0] ignored. No wrap: a burst incrementing past the top goes out of range.
- States: IDLE, WR_DATA, WR_RESP, RD_MEM, RD_RESP.
- IDLE:
  - AW handshake: latch awaddr, clear err, go to WR_DATA.
  - Else AR handshake: latch araddr, beat=0, err=0, go to RD_MEM.
  - wvalid in IDLE is ignored (wready=0).
- WR_DATA, on wvalid&&wready:
  - In range: write each byte i where wstrb[i]=1. If wstrb==0, no write.
  - Out of range: discard, set err.
  - addr += 4.
  - If wlast: bresp = err ? 2'b10 : 2'b00, bvalid=1, go to WR_RESP. Otherwise stay in WR_DATA.
  - Any number of beats is accepted; wlast alone terminates.
- WR_RESP:
  - WAIT_BREADY=1: hold bvalid/bresp until bready, then bvalid=0, IDLE.
  - WAIT_BREADY=0: bvalid=0 after one cycle, IDLE.
- RD_MEM: one RAM read cycle. Next cycle: rdata = RAM word (or 32'h0 if out of range), rresp = out-of-range ? 2'b10 : 2'b00, rlast = (beat==RD_BEATS-1), rvalid=1, go to RD_RESP.
- Read latency: AR handshake at cycle N gives rvalid at N+2.
- RD_RESP: rdata/rresp/rlast held stable while rvalid && !rready. On rready:
  - rvalid=0, rlast=0.
  - If last: go to IDLE.
  - Else: beat+1, addr+=4, go to RD_MEM.
- Throughput: write bursts run at 1 beat/cycle; read beats need at least 2 cycles each.
- Reset mid-burst: transaction is abandoned with no response; beats already written remain in RAM.

Test Plan:
- Single write then read: AW 0x10, W 0xDEADBEEF, wstrb 4'hF, wlast=1, bready=1 -> bresp 00. Then AR 0x10 -> rvalid 2 cycles after the AR handshake, rdata 0xDEADBEEF, rlast=1, rresp 00.
- Byte strobes: word 0x10 holds 0xDEADBEEF; write 0x11223344 with wstrb 4'b0101 -> readback 0xDE22BE44.
- Burst write and burst read: AW 0x20; beats 1,2,3 with wlast on beat 3 -> single bvalid. With RD_BEATS=3, AR 0x20 -> rdata 1,2,3 in order; rlast only on the third beat; rready toggled 0/1 must not change the held data.
- Range errors, MEM_DEPTH=4:
  - Write 0x0C (2 beats) -> bresp 10; word 3 written, 0x10 discarded.
  - AR 0x40 -> rdata 0, rresp 10.
- Simultaneous AW 0x0 and AR 0x4 in the same cycle -> write completes first; arready rises only after return to IDLE; read is served after.
- Mid-burst reset and WAIT_BREADY=0:
  - resetn low for 1 cycle after the 2nd write beat -> all valids 0; awready=1 next cycle; the 2 beats are retained.
  - WAIT_BREADY=0 with bready tied 0 -> bvalid is a 1-cycle pulse and the next AW is accepted.
